// File: rtl/lmsm_sequencer_if.sv
// Pipe1-side bus of the LM/SM sequencer: the instruction it watches, the
// downstream handshake, and the single-register micro-op it emits.
// master = the sequencer, slave = decode/execute and the pipe1 controller.
interface lmsm_sequencer_if #(
    parameter int REG_AW = 3,
    parameter int OFS_W  = 4
);
    logic              ir_valid;
    logic [15:0]       fromPipe1IR;
    logic              stall_in;
    logic              flush;
    logic              hold_pipe1;
    logic              uop_valid;
    logic [1:0]        uop_kind;
    logic [REG_AW-1:0] uop_base;
    logic [REG_AW-1:0] uop_reg;
    logic [OFS_W-1:0]  uop_offset;
    logic              uop_last;

    modport master (
        input  ir_valid, fromPipe1IR, stall_in, flush,
        output hold_pipe1, uop_valid, uop_kind, uop_base, uop_reg,
               uop_offset, uop_last
    );

    modport slave (
        output ir_valid, fromPipe1IR, stall_in, flush,
        input  hold_pipe1, uop_valid, uop_kind, uop_base, uop_reg,
               uop_offset, uop_last
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// LM/SM multi-cycle sequencer. Splits one LM/SM in pipe1 into one
// load/store micro-op per selected register, ascending register order,
// while holding fetch/pipe1.
// Optional feature macro: LMSM_BASE_WB_EN -- adds a WB state that emits a
// final base write-back micro-op (kind 10, RA += number of transfers).
module lmsm_sequencer #(
    parameter int MASK_W = 8,
    parameter int REG_AW = 3,
    parameter int OFS_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    lmsm_sequencer_if.master  bus
);

`ifdef LMSM_BASE_WB_EN
    typedef enum logic [1:0] {IDLE, RUN, WB} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t              state_q, state_d;
    logic [MASK_W-1:0]   mask_q, mask_d;
    logic [REG_AW-1:0]   base_q, base_d;
    logic                kind_q, kind_d;
    logic [OFS_W-1:0]    count_q, count_d;

    logic [15:0]         ir;
    logic                accept;
    logic                one_left;
    logic [REG_AW-1:0]   low_idx;
    logic                unused_ir;

    assign ir        = bus.fromPipe1IR;
    // IR[8] carries no meaning for LM/SM
    assign unused_ir = ir[8];

    assign accept   = (state_q == IDLE) & bus.ir_valid & (ir[15:13] == 3'b011)
                    & (ir[MASK_W-1:0] != '0) & ~bus.flush;
    // Exactly one bit left: nonzero and clearing the lowest bit empties it
    assign one_left = (mask_q != '0) & ((mask_q & (mask_q - MASK_W'(1))) == '0);

    // Priority encode the lowest remaining mask bit (scan high to low, last hit wins)
    always_comb begin
        low_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask_q[i]) low_idx = REG_AW'(i);
        end
    end

    // State and datapath registers; reset is synchronous and overrides all
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mask_q  <= '0;
            base_q  <= '0;
            kind_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            base_q  <= base_d;
            kind_q  <= kind_d;
            count_q <= count_d;
        end
    end

    // Next state: latch on accept, advance one register per consumed micro-op
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        base_d  = base_q;
        kind_d  = kind_q;
        count_d = count_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = RUN;
                        mask_d  = ir[MASK_W-1:0];
                        base_d  = ir[9 +: REG_AW];
                        kind_d  = ir[12];
                        count_d = '0;
                    end
                end
                RUN: begin
                    if (!bus.stall_in) begin
                        mask_d  = mask_q & (mask_q - MASK_W'(1));
                        count_d = count_q + OFS_W'(1);
`ifdef LMSM_BASE_WB_EN
                        if (one_left) state_d = WB;
`else
                        if (one_left) state_d = IDLE;
`endif
                    end
                end
`ifdef LMSM_BASE_WB_EN
                WB: begin
                    if (!bus.stall_in) state_d = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Micro-op outputs decode registered state only; idle outputs read as zero
    always_comb begin
        bus.uop_valid  = 1'b0;
        bus.uop_kind   = 2'b00;
        bus.uop_base   = '0;
        bus.uop_reg    = '0;
        bus.uop_offset = '0;
        bus.uop_last   = 1'b0;
        case (state_q)
            RUN: begin
                bus.uop_valid  = 1'b1;
                bus.uop_kind   = {1'b0, kind_q};
                bus.uop_base   = base_q;
                bus.uop_reg    = low_idx;
                bus.uop_offset = count_q;
`ifdef LMSM_BASE_WB_EN
                bus.uop_last   = 1'b0;
`else
                bus.uop_last   = one_left;
`endif
            end
`ifdef LMSM_BASE_WB_EN
            WB: begin
                bus.uop_valid  = 1'b1;
                bus.uop_kind   = 2'b10;
                bus.uop_base   = base_q;
                bus.uop_reg    = base_q;
                bus.uop_offset = count_q;
                bus.uop_last   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Hold pipe1 until the final micro-op leaves; a flush releases it at once
    always_comb begin
        bus.hold_pipe1 = ~bus.flush &
                         (accept | (bus.uop_valid & ~(bus.uop_last & ~bus.stall_in)));
    end

endmodule
